// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: unsigned magnitude compare of two BYTES-wide words,
// one byte per clock, most-significant byte first. An 8-bit cascadable
// slice carries eq/gt from byte to byte, so no wide comparator is built.
//
// Optional macro: SERIAL_MAG_CMP_EARLY_EXIT_EN. When defined, the compare
// ends on the first differing byte. Equal words still take BYTES cycles.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            request; only sampled while busy=0
//   a_word, b_word   operands; [W-1:W-8] is the most significant byte
//   busy             a compare is in progress
//   done             one-cycle pulse: eq/gt/lt_out were just updated
//   eq_out/gt_out/lt_out  registered one-hot verdict, held until next done

// Cascadable 8-bit slice. Once a higher byte has differed (eq_in=0), the
// verdict is already decided and passes through unchanged.
module mag_cmp_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       eq_in,
  input  logic       gt_in,
  output logic       eq,
  output logic       gt
);
  assign eq = eq_in & (a == b);
  assign gt = gt_in | (eq_in & (a > b));
endmodule

module serial_mag_cmp #(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8*BYTES-1:0]   a_word,
  input  logic [8*BYTES-1:0]   b_word,
  output logic                 busy,
  output logic                 done,
  output logic                 eq_out,
  output logic                 gt_out,
  output logic                 lt_out
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [BYTES-1:0][7:0]  a_q, b_q;
  logic [IW-1:0]          idx;
  logic                   eq_c, gt_c;
  logic                   eq_n, gt_n;
  logic                   last, load, finish;

  mag_cmp_slice u_slice (
    .a     (a_q[idx]),
    .b     (b_q[idx]),
    .eq_in (eq_c),
    .gt_in (gt_c),
    .eq    (eq_n),
    .gt    (gt_n)
  );

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
  // With early exit, eq_c is always 1 while running, so eq_n=0 means this
  // byte is the first one that differs.
  assign last = (idx == '0) | ~eq_n;
`else
  assign last = (idx == '0);
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (last) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      eq_c   <= 1'b0;
      gt_c   <= 1'b0;
      done   <= 1'b0;
      eq_out <= 1'b1;
      gt_out <= 1'b0;
      lt_out <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (load) begin
        a_q  <= a_word;
        b_q  <= b_word;
        eq_c <= 1'b1;
        gt_c <= 1'b0;
        idx  <= IW'(BYTES - 1);
      end else if (state == RUN) begin
        eq_c <= eq_n;
        gt_c <= gt_n;
        // Exit is decided by idx==0; never let idx wrap.
        if (!last) idx <= idx - 1'b1;
      end
      if (finish) begin
        eq_out <= eq_n;
        gt_out <= gt_n;
        lt_out <= ~eq_n & ~gt_n;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp (BYTES=4): directed scenarios
// plus randomized compares against an arithmetic reference model.
module tb_serial_mag_cmp;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         busy, done, eq_out, gt_out, lt_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.BYTES(BYTES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_word (a_word),
    .b_word (b_word),
    .busy   (busy),
    .done   (done),
    .eq_out (eq_out),
    .gt_out (gt_out),
    .lt_out (lt_out)
  );

  // Expected start-to-done cycles.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
    for (int k = 0; k < BYTES; k++)
      if (a[W-1-8*k -: 8] != b[W-1-8*k -: 8]) return k + 1;
    return BYTES;
`else
    return BYTES;
`endif
  endfunction

  // Stimulus driver. Called at #1 after a rising edge; returns at #1 after
  // the edge that raised done (lat=0 on timeout). Operands are scrambled
  // right after acceptance to show the latched copy is used.
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit busy_ok);
    a_word = a; b_word = b; start = 1'b1;
    busy_ok = 1'b1; lat = 0;
    @(posedge clk); #1;
    start = 1'b0; a_word = ~a; b_word = a;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic check_res(input string nm, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int lat, input bit busy_ok);
    logic [2:0] got, want;
    got  = {eq_out, gt_out, lt_out};
    want = {a == b, a > b, a < b};
    total++;
    if (lat == 0) begin
      bad++; $display("FAIL %s timeout: no done within 64 cycles", nm);
    end else if (lat != exp_lat(a, b)) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat(a, b));
    end
    total++;
    if (got !== want) begin
      bad++; $display("FAIL %s verdict a=%h b=%h: got eq/gt/lt=%b want %b", nm, a, b, got, want);
    end
    total++;
    if (!busy_ok) begin
      bad++; $display("FAIL %s busy profile: busy not high through run or not low at done", nm);
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, eq_out, gt_out, lt_out} !== 5'b00100) begin
      bad++; $display("FAIL reset_state: got busy/done/eq/gt/lt=%b want 00100",
                      {busy, done, eq_out, gt_out, lt_out});
    end
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
    end
    total++;
    if (cnt != 0) begin
      bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", cnt);
    end
  endtask

  task automatic test_equal();
    int lat; bit ok;
    do_cmp('0, '0, lat, ok);
    check_res("equal_zero", '0, '0, lat, ok);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_single: got done=%b want 0", done);
    end
  endtask

  task automatic test_lsb();
    int lat; bit ok;
    do_cmp(32'h0000_0001, 32'h0000_0000, lat, ok);
    check_res("lsb_gt", 32'h0000_0001, 32'h0000_0000, lat, ok);
    // back-to-back: start presented in the done cycle
    do_cmp(32'h0000_0000, 32'h0000_0001, lat, ok);
    check_res("lsb_lt_b2b", 32'h0000_0000, 32'h0000_0001, lat, ok);
  endtask

  task automatic test_msb();
    int lat; bit ok;
    repeat (2) @(posedge clk); #1;
    do_cmp(32'h8000_0000, 32'h7FFF_FFFF, lat, ok);
    check_res("msb_gt", 32'h8000_0000, 32'h7FFF_FFFF, lat, ok);
  endtask

  task automatic test_busy_protect();
    int dones; logic [2:0] first;
    repeat (2) @(posedge clk); #1;
    a_word = 32'h0000_0105; b_word = 32'h0000_0103; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    a_word = 32'h0000_0000; b_word = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dones = 0; first = 3'b000;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (dones == 0) first = {eq_out, gt_out, lt_out};
        dones++;
      end
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL busy_one_done: got %0d done pulses want 1", dones);
    end
    total++;
    if (first !== 3'b010) begin
      bad++; $display("FAIL busy_first_ops: got eq/gt/lt=%b want 010", first);
    end
  endtask

  task automatic test_mid_reset();
    int dones, lat; bit ok;
    a_word = 32'h0000_0001; b_word = 32'h0000_0000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); rst_n = 1'b0; #1;
    total++;
    if ({busy, done, eq_out, gt_out, lt_out} !== 5'b00100) begin
      bad++; $display("FAIL midreset_state: got busy/done/eq/gt/lt=%b want 00100",
                      {busy, done, eq_out, gt_out, lt_out});
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done !== 1'b0) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL midreset_no_done: got %0d done cycles want 0", dones);
    end
    do_cmp(32'h1234_5678, 32'h1234_5679, lat, ok);
    check_res("after_reset_lt", 32'h1234_5678, 32'h1234_5679, lat, ok);
  endtask

  task automatic test_random();
    int lat; bit ok; logic [W-1:0] a, b; int keep;
    for (int n = 0; n < 40; n++) begin
      a = $urandom; b = $urandom;
      // share a random-length MSB prefix so every byte position decides sometimes
      keep = $urandom_range(0, BYTES);
      for (int k = 0; k < keep; k++) b[W-1-8*k -: 8] = a[W-1-8*k -: 8];
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      do_cmp(a, b, lat, ok);
      check_res("random", a, b, lat, ok);
      total++;
      if ((32'(eq_out) + 32'(gt_out) + 32'(lt_out)) != 1) begin
        bad++; $display("FAIL onehot: got eq/gt/lt=%b want exactly one set",
                        {eq_out, gt_out, lt_out});
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_lsb();
    test_msb();
    test_busy_protect();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_mag_cmp.md
Name: serial_mag_cmp

Overview:
- Multi-byte unsigned magnitude comparator: two BYTES-wide words compared one byte per clock, most-significant byte first.
- An 8-bit cascadable compare slice carries eq/gt between bytes.
- Sits upstream of the datapath's 8-bit compare stage: reduces wide operands to a single registered EQ/GT/LT verdict with a start/done handshake.
- Consumers: sorting/priority logic needing wide compares without a wide combinational comparator.

Parameters:
- BYTES, 4, operand width in bytes (legal 2..16); word width W = 8*BYTES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- a_word  in  W  operand A, unsigned; [W-1:W-8] is the most significant byte
- b_word  in  W  operand B, unsigned, same layout
- busy  out  1  high while a compare is in progress
- done  out  1  one-cycle pulse: result valid and updated
- eq_out  out  1  A == B (registered, held until next done)
- gt_out  out  1  A > B (registered, held)
- lt_out  out  1  A < B (registered, held)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, eq_out=1, gt_out=0, lt_out=0; operand regs, index and cascade regs cleared.
  - Reset mid-compare aborts immediately: no done pulse, outputs return to reset values.
- States:
  - IDLE: start=1 at edge 0 latches a_word/b_word, sets cascade eq_c=1, gt_c=0, idx=BYTES-1, goes to RUN, busy=1.
  - RUN: each edge processes byte idx:
    - if eq_c=1: eq_c <= (A[idx]==B[idx]) and gt_c <= (A[idx]>B[idx]);
    - if eq_c=0: eq_c/gt_c hold;
    - idx decrements.
    - The edge processing idx=0 (edge BYTES) loads eq_out=eq_c', gt_out=gt_c', lt_out=~eq_c' & ~gt_c', asserts done for the following cycle, clears busy, returns to IDLE.
- Latency: done high in the cycle after edge BYTES; start-to-done = BYTES cycles.
- Throughput: start may be asserted in the done cycle and is accepted, so back-to-back compares run every BYTES cycles.
- start while busy=1: ignored, no queuing; a_word/b_word changes during RUN have no effect (latched copy used).
- Outputs are mutually exclusive: exactly one of eq_out/gt_out/lt_out is 1 at all times after reset.
- done is never asserted for two consecutive cycles unless two separate compares complete.
- idx wraps never: RUN exit is governed by idx==0, not underflow.

Optional Feature:
- Macro SERIAL_MAG_CMP_EARLY_EXIT_EN.
- Defined: in RUN, the first byte with A[idx]!=B[idx] terminates the compare on that edge, with outputs loaded and done pulsed.
  - Latency = position of first differing byte counted from MSB (1..BYTES).
  - Equal words still take BYTES cycles.
- Undefined: fixed BYTES-cycle latency regardless of data, as specified above.

Test Plan (BYTES=4):
- Reset then idle:
  - rst_n low 3 cycles -> eq_out=1, gt_out=0, lt_out=0, busy=0, done=0.
  - No done while start=0 for 20 cycles.
- Equal compare:
  - A=B=0x00000000, start at edge 0 -> busy 1 for edges 0..3, done pulse after edge 4, eq_out=1, gt_out=0, lt_out=0.
- LSB difference:
  - A=0x00000001, B=0x00000000 -> gt_out=1 after 4 cycles.
  - Then A=0x00000000, B=0x00000001 -> lt_out=1; back-to-back start in done cycle accepted.
- MSB dominates:
  - A=0x80000000, B=0x7FFFFFFF -> gt_out=1.
  - With SERIAL_MAG_CMP_EARLY_EXIT_EN: done after 1 cycle. Without: done after 4 cycles.
- Busy protection:
  - start re-asserted with new operands during RUN -> ignored.
  - Result reflects first operands; only one done pulse.
- Mid-operation reset:
  - rst_n low at edge 2 of a compare -> busy=0, no done, eq_out=1.
  - Next compare A=0x12345678, B=0x12345679 -> lt_out=1.
